im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Boot loader for the single-cycle MIPS core. It is the write side of the 1 KB instruction memory; the fetch unit is the read side.
- Accepts a byte stream through a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction memory write port at consecutive word addresses.
- Holds the CPU in reset while loading. On release the fetch unit restarts at PC 0x0000_3000, and im byte offset 0x000 maps to that PC.

Parameters:
- DEPTH_WORDS, 256: instruction memory capacity in words (1 KB).
- CNT_W, 16: width of the word-count header, in bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  begin a load; sampled only in IDLE, DONE or ERR
- in_valid  input  1  byte stream valid
- in_data  input  8  byte stream data
- in_ready  output  1  loader accepts a byte this cycle
- im_we  output  1  instruction memory write enable
- im_addr  output  10  byte address, always word aligned (bits [1:0] = 0)
- im_wdata  output  32  instruction word
- cpu_hold  output  1  drives the core/fetch-unit reset; 1 = core held
- busy  output  1  load in progress
- done  output  1  one-cycle pulse when the load completes
- error  output  1  header count exceeds DEPTH_WORDS; sticky
- words_loaded  output  9  number of words written in the current or last load

Behaviour:
- Reset values: state IDLE, in_ready 0, im_we 0, im_addr 0, im_wdata 0, cpu_hold 1, busy 0, done 0, error 0, words_loaded 0.
- Handshake: a byte is accepted when in_valid && in_ready. in_ready is 1 only in CNT_HI, CNT_LO and DATA. The memory write never stalls, so no other backpressure exists.
- States:
  - IDLE: cpu_hold 1. start -> CNT_HI.
  - CNT_HI: accepted byte -> count[15:8]. -> CNT_LO.
  - CNT_LO: accepted byte -> count[7:0].
    - count == 0 -> DONE.
    - count > DEPTH_WORDS -> ERR.
    - otherwise -> DATA; word index cleared, byte lane cleared.
  - DATA: accepted bytes fill the word MSB first (lane 0 -> [31:24] ... lane 3 -> [7:0]).
    - On the lane-3 accept, the next cycle shows im_we=1, im_addr = word_index<<2, im_wdata = assembled word; words_loaded increments in that same cycle.
    - After the final word's im_we cycle -> DONE.
    - Bytes may arrive back-to-back; a 4th byte of the next word can be accepted while the previous im_we is high.
  - DONE: done=1 for the first cycle only. cpu_hold 0, busy 0, in_ready 0. start -> CNT_HI, cpu_hold back to 1 in that same transition.
  - ERR: error=1, cpu_hold 1, in_ready 0, no writes. start -> CNT_HI and clears error.
- busy = 1 in CNT_HI, CNT_LO and DATA.
- im_we is a single-cycle pulse per word. im_addr and im_wdata hold their last value when im_we=0.
- Latency:
  - final byte accepted -> im_we: 1 cycle.
  - final byte accepted -> done pulse and cpu_hold falling: 2 cycles.
  - The last write is therefore committed before the core leaves reset.
- start while busy: ignored.
- start in the same cycle as an accepted byte in DONE/ERR: cannot occur, because in_ready is 0 there.
- Wrap-around:
  - count == DEPTH_WORDS is legal; the last address is 0x3FC.
  - The word index never wraps, because oversize counts go to ERR.
- Reset mid-load: returns to IDLE the next edge. Any partially assembled word is discarded, no im_we is issued for it, and words_loaded is cleared. Memory words already written stay written.
- Width rules: the count comparison is unsigned over CNT_W bits; words_loaded is 9 bits so it can represent 256.

Decomposition:
- Package mips_loader_pkg:
  - state encoding (IDLE, CNT_HI, CNT_LO, DATA, DONE, ERR)
  - IM_BOOT_PC = 32'h0000_3000
  - IM_DEPTH_WORDS = 256
  - IM_ADDR_W = 10
- Sub-module byte_packer:
  - 2-bit lane counter and 32-bit shift register.
  - Outputs word_valid, a one-cycle pulse on the lane-3 accept, together with the word.
  - Has a clear input used on reset and at header end.
- The top level holds the FSM, count register, word index and output registers.

Test Plan:
- Reset asserted 2 cycles -> in_ready 0, im_we 0, cpu_hold 1, busy 0, done 0, error 0, words_loaded 0.
- start, then bytes 00 02 34 08 00 05 20 09 00 0A back-to-back ->
  - im_we at addr 0x000 with data 0x34080005;
  - im_we at addr 0x004 with data 0x2009000A;
  - done pulse 2 cycles after the last byte, cpu_hold 0, words_loaded 2.
- Same stream with in_valid low for random gaps of 0-3 cycles -> identical writes and data; no im_we during gaps; no duplicate accepts.
- Header 01 01 (257) -> ERR, error 1, in_ready 0, no im_we. A later start plus header 00 00 -> done pulse and error cleared.
- Header 01 00 with 1024 data bytes -> 256 writes, last at addr 0x3FC; done, then cpu_hold 0.
- Header 00 03, then reset after 6 data bytes -> exactly one write (addr 0x000), no write for the partial word, back in IDLE with cpu_hold 1 and words_loaded 0.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader of the single-cycle MIPS core.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        DONE,
        ERR
    } loader_state_t;

    // The fetch unit restarts here, and im byte offset 0x000 maps to this PC.
    localparam logic [31:0] IM_BOOT_PC     = 32'h0000_3000;
    localparam int          IM_DEPTH_WORDS = 256;
    localparam int          IM_ADDR_W      = 10;

endpackage

// File: rtl/im_loader_if.sv
// Byte stream in and instruction-memory write port out, bundled for the loader.
// The slave modport is the loader itself; master is whoever feeds bytes and owns the memory.
interface im_loader_if;
    import mips_loader_pkg::*;

    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 im_we;
    logic [IM_ADDR_W-1:0] im_addr;
    logic [31:0]          im_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata
    );

endinterface

// File: rtl/im_loader_byte_packer.sv
// Collects accepted bytes MSB first into big-endian 32-bit words.
module byte_packer (
    input  logic        clk,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [23:0] shift;

    always_ff @(posedge clk) begin
        if (clear) begin
            lane  <= 2'd0;
            shift <= 24'd0;
        end else if (byte_en) begin
            shift <= {shift[15:0], byte_in};
            lane  <= lane + 2'd1;
        end
    end

    // The fourth byte completes the word combinationally so the top can register it in one cycle.
    assign word_valid = byte_en && (lane == 2'd3) && !clear;
    assign word       = {shift, byte_in};

endmodule

// File: rtl/im_loader.sv
// Boot loader: header-counted byte stream into instruction memory, CPU held in reset meanwhile.
module im_loader
    import mips_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = IM_DEPTH_WORDS,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    im_loader_if.slave  bus,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  words_loaded
);

    loader_state_t    state;
    logic [7:0]       count_hi;
    logic [CNT_W-1:0] count;
    logic [8:0]       word_index;

    logic             accept;
    logic             header_end;
    logic             packer_clear;
    logic             word_valid;
    logic [31:0]      word;
    logic [CNT_W-1:0] header_count;
    logic [CNT_W-1:0] next_index;

    assign accept       = bus.in_valid && bus.in_ready;
    assign header_end   = accept && (state == CNT_LO);
    assign packer_clear = reset || header_end;
    assign header_count = CNT_W'({count_hi, bus.in_data});
    assign next_index   = CNT_W'(word_index) + CNT_W'(1);

    byte_packer u_packer (
        .clk        (clk),
        .clear      (packer_clear),
        .byte_en    (accept && (state == DATA)),
        .byte_in    (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Dropping in_ready on the final word leaves DATA one cycle to commit that write
    // before DONE releases the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= 32'd0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 9'd0;
            count_hi     <= 8'd0;
            count        <= '0;
            word_index   <= 9'd0;
        end else begin
            bus.im_we <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= CNT_HI;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        error        <= 1'b0;
                        words_loaded <= 9'd0;
                    end
                end
                CNT_HI: begin
                    if (accept) begin
                        count_hi <= bus.in_data;
                        state    <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (accept) begin
                        count      <= header_count;
                        word_index <= 9'd0;
                        if (header_count == '0) begin
                            state        <= DONE;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            cpu_hold     <= 1'b0;
                        end else if (header_count > CNT_W'(DEPTH_WORDS)) begin
                            state        <= ERR;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            error        <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        bus.im_we    <= 1'b1;
                        bus.im_addr  <= {word_index[7:0], 2'b00};
                        bus.im_wdata <= word;
                        words_loaded <= words_loaded + 9'd1;
                        word_index   <= word_index + 9'd1;
                        if (next_index == count) begin
                            bus.in_ready <= 1'b0;
                        end
                    end else if (!bus.in_ready) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: header table, random data and gaps, reset corner cases.
module tb_im_loader;
    import mips_loader_pkg::*;

    typedef struct {
        string      name;
        logic [15:0] count;
        int         gap;
        bit         use_prog;
        logic       exp_err;
        logic [8:0] exp_words;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] words_loaded;

    im_loader_if bus ();

    im_loader #(.DEPTH_WORDS(256), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    int   acc_cnt = 0;
    int   last_acc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   last_we_cyc = 0;
    logic hold_at_done = 1'b1;
    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    logic [7:0] prog [8];
    vec_t       vecs [8];

    // Accepts are counted on the edge that takes them; DUT outputs are observed on the falling edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && bus.in_valid && bus.in_ready) begin
            acc_cnt  <= acc_cnt + 1;
            last_acc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.im_we) begin
            wr_addr_q.push_back(bus.im_addr);
            wr_data_q.push_back(bus.im_wdata);
            last_we_cyc <= cyc;
        end
        if (done) begin
            done_cnt     <= done_cnt + 1;
            done_cyc     <= cyc;
            hold_at_done <= cpu_hold;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap, input bit poke_start);
        int t;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            start = poke_start && ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_output("in_ready_wait", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic [7:0]  bytes[$];
        logic [31:0] exp_data[$];
        int n_words;
        int a0;
        int d0;
        int q0;
        int nw;

        n_words = v.exp_err ? 0 : int'(v.count);
        bytes.push_back(v.count[15:8]);
        bytes.push_back(v.count[7:0]);
        for (int i = 0; i < n_words * 4; i++) begin
            if (v.use_prog && i < 8) bytes.push_back(prog[i]);
            else bytes.push_back(8'($urandom));
        end
        for (int i = 0; i < n_words; i++) begin
            exp_data.push_back({bytes[2+4*i], bytes[3+4*i], bytes[4+4*i], bytes[5+4*i]});
        end

        a0 = acc_cnt;
        d0 = done_cnt;
        q0 = wr_addr_q.size();

        pulse_start();
        check_output({v.name, "_busy_after_start"}, busy, 1);
        check_output({v.name, "_hold_after_start"}, cpu_hold, 1);

        foreach (bytes[i]) begin
            push_byte(bytes[i], (v.gap > 0) ? $urandom_range(0, v.gap) : 0, v.gap > 0);
        end

        for (int t = 0; t < 8 && !(done || error); t++) @(negedge clk);
        repeat (3) @(negedge clk);

        nw = wr_addr_q.size() - q0;
        check_output({v.name, "_write_count"}, nw, n_words);
        for (int i = 0; i < n_words && i < nw; i++) begin
            check_output($sformatf("%s_addr%0d", v.name, i), wr_addr_q[q0+i], i * 4);
            check_output($sformatf("%s_data%0d", v.name, i), wr_data_q[q0+i], exp_data[i]);
        end
        check_output({v.name, "_accepts"}, acc_cnt - a0, bytes.size());
        check_output({v.name, "_done_pulses"}, done_cnt - d0, v.exp_err ? 0 : 1);
        check_output({v.name, "_words_loaded"}, words_loaded, v.exp_words);
        check_output({v.name, "_error"}, error, v.exp_err);
        check_output({v.name, "_cpu_hold"}, cpu_hold, v.exp_err);
        check_output({v.name, "_busy_end"}, busy, 0);
        check_output({v.name, "_in_ready_end"}, bus.in_ready, 0);
        if (!v.exp_err) begin
            check_output({v.name, "_done_latency"}, done_cyc - last_acc, (n_words > 0) ? 1 : 0);
            check_output({v.name, "_hold_at_done"}, hold_at_done, 0);
        end
        if (n_words > 0) begin
            check_output({v.name, "_we_latency"}, last_we_cyc - last_acc, 0);
            check_output({v.name, "_addr_hold"}, bus.im_addr, (n_words - 1) * 4);
            check_output({v.name, "_data_hold"}, bus.im_wdata, exp_data[n_words-1]);
        end
    endtask

    initial begin
        logic [31:0] first_word;
        int q0;

        prog = '{8'h34, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
        vecs[0] = '{"prog",           16'd2,     0, 1'b1, 1'b0, 9'd2};
        vecs[1] = '{"prog_gaps",      16'd2,     3, 1'b1, 1'b0, 9'd2};
        vecs[2] = '{"over_257",       16'd257,   0, 1'b0, 1'b1, 9'd0};
        vecs[3] = '{"zero_after_err", 16'd0,     0, 1'b0, 1'b0, 9'd0};
        vecs[4] = '{"one_word",       16'd1,     2, 1'b0, 1'b0, 9'd1};
        vecs[5] = '{"full_256",       16'd256,   0, 1'b0, 1'b0, 9'd256};
        vecs[6] = '{"over_ffff",      16'hFFFF,  1, 1'b0, 1'b1, 9'd0};
        vecs[7] = '{"five_gaps",      16'd5,     3, 1'b0, 1'b0, 9'd5};

        $display("[TB] im_loader bench, boot PC %h", IM_BOOT_PC);
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (2) @(negedge clk);
        check_output("rst_in_ready", bus.in_ready, 0);
        check_output("rst_im_we", bus.im_we, 0);
        check_output("rst_cpu_hold", cpu_hold, 1);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_error", error, 0);
        check_output("rst_words_loaded", words_loaded, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        if (wr_data_q.size() >= 2) begin
            check_output("prog_word0_const", wr_data_q[0], 32'h34080005);
            check_output("prog_word1_const", wr_data_q[1], 32'h2009000A);
        end else begin
            check_output("prog_word_count_const", wr_data_q.size(), 4);
        end

        // Reset after six data bytes of a three-word load: only the first word may land.
        q0 = wr_addr_q.size();
        pulse_start();
        push_byte(8'h00, 0, 1'b0);
        push_byte(8'h03, 0, 1'b0);
        first_word = $urandom;
        for (int i = 0; i < 4; i++) push_byte(first_word[31-8*i -: 8], 0, 1'b0);
        push_byte(8'($urandom), 0, 1'b0);
        push_byte(8'($urandom), 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_output("midrst_in_ready", bus.in_ready, 0);
        check_output("midrst_cpu_hold", cpu_hold, 1);
        check_output("midrst_words_loaded", words_loaded, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_im_we", bus.im_we, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("midrst_write_count", wr_addr_q.size() - q0, 1);
        if (wr_addr_q.size() > q0) begin
            check_output("midrst_addr0", wr_addr_q[q0], 0);
            check_output("midrst_data0", wr_data_q[q0], first_word);
        end

        apply_stimulus('{"after_reset", 16'd1, 0, 1'b0, 1'b0, 9'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
